alu_wide_sequencer: RTL

//  Initiator/controller for the 8-bit combinational ALU: accepts one multi-byte op
//  per handshake, drives the ALU ctrl/operand/carry inputs one byte per cycle
//  (LSB first), registers each alu_out byte and chains alu_cout between passes.

---
 rtl/alu_wide_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_wide_sequencer.sv
// Multi-byte sequencer for an 8-bit combinational ALU: walks the operands one byte
// per cycle (LSB first), chaining the carry through the ALU between passes.
module alu_wide_sequencer #(
   parameter int  NBYTES = 2,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         ready_o,
   output logic         done_o,
   output logic [W-1:0] result_o,
   output logic         carry_o,
   output logic [3:0]   alu_ctrl_o,
   output logic [7:0]   alu_a_o,
   output logic [7:0]   alu_b_o,
   output logic         alu_cin_o,
   input  logic [7:0]   alu_out_i,
   input  logic         alu_cout_i
);

   // state | meaning
   // IDLE  | waiting for start_i, ready_o high
   // NEGB  | inverting b one byte per cycle (SUB only)
   // ARITH | one result byte per cycle, carry chained through r_c
   // DONE  | one-cycle done_o pulse, result_o/carry_o valid

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   // ALU opcode encoding shared with the ALU's definitions package
   localparam logic [3:0] K_ADDC = 4'h1;
   localparam logic [3:0] K_NEG  = 4'h3;
   localparam logic [3:0] K_AND  = 4'h4;
   localparam logic [3:0] K_OR   = 4'h5;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NEGB  = 2'd1,
      S_ARITH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [IW-1:0]            r_idx;
   logic                     r_c;
   logic [1:0]               r_op;
   logic [NBYTES-1:0][7:0]   r_a;
   logic [NBYTES-1:0][7:0]   r_b;
   logic [NBYTES-1:0][7:0]   r_res;
   logic [NBYTES-1:0][7:0]   w_res_nxt;
   logic                     w_last;
   logic                     w_arith_op;

   assign w_last     = (r_idx == LAST_IDX);
   assign w_arith_op = (r_op == OP_ADD) || (r_op == OP_SUB);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = (op_i == OP_SUB) ? S_NEGB : S_ARITH;
            end
         end
         S_NEGB: begin
            if (w_last) begin
               w_state_nxt = S_ARITH;
            end
         end
         S_ARITH: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      ready_o    = (r_state == S_IDLE);
      done_o     = (r_state == S_DONE);
      alu_ctrl_o = K_AND;
      alu_a_o    = 8'h00;
      alu_b_o    = 8'h00;
      alu_cin_o  = 1'b0;
      case (r_state)
         S_NEGB: begin
            alu_ctrl_o = K_NEG;
            alu_a_o    = r_b[r_idx];
         end
         S_ARITH: begin
            alu_a_o = r_a[r_idx];
            alu_b_o = r_b[r_idx];
            case (r_op)
               OP_ADD, OP_SUB: begin
                  alu_ctrl_o = K_ADDC;
                  alu_cin_o  = r_c;
               end
               OP_AND:  alu_ctrl_o = K_AND;
               OP_OR:   alu_ctrl_o = K_OR;
               default: alu_ctrl_o = K_AND;
            endcase
         end
         default: begin
            alu_ctrl_o = K_AND;
         end
      endcase
   end

   // Last byte bypasses r_res so result_o is complete on the edge into DONE.
   always_comb begin
      w_res_nxt        = r_res;
      w_res_nxt[r_idx] = alu_out_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx    <= '0;
         r_c      <= 1'b0;
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         result_o <= '0;
         carry_o  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_op  <= op_i;
                  r_a   <= a_i;
                  r_b   <= b_i;
                  r_idx <= '0;
                  r_c   <= (op_i == OP_SUB);
               end
            end
            S_NEGB: begin
               r_b[r_idx] <= alu_out_i;
               r_idx      <= w_last ? '0 : r_idx + 1'b1;
            end
            S_ARITH: begin
               r_res[r_idx] <= alu_out_i;
               if (w_arith_op) begin
                  r_c <= alu_cout_i;
               end
               if (w_last) begin
                  r_idx    <= '0;
                  result_o <= w_res_nxt;
                  carry_o  <= w_arith_op ? alu_cout_i : 1'b0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
